instr_mem_loadable: RTL and testbench

- Parametrised successor to the fixed 32x32 instruction ROM: word-addressed instruction memory, loaded at boot through a write port, then serving registered fetches to the CPU front end.
- Two-phase operation: LOAD (program download from the testbench or boot loader), then RUN (write-protected fetch with stall hold).
- Per-word written flags detect fetches of never-loaded words; out-of-range addresses are flagged.

---
 rtl/instr_mem_loadable.sv | 129 ++++++++++++
 tb/tb_instr_mem_loadable.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loadable.sv
// Word-addressed instruction memory: program download in LOAD, then
// write-protected registered fetches with stall hold in RUN.
module instr_mem_loadable #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 32,
  parameter int                    ADDR_WIDTH = 5,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_we,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_done,
  output logic                  load_err,
  output logic                  running,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  input  logic                  fetch_stall,
  output logic                  fetch_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  output logic                  fetch_err,
  output logic                  fetch_uninit
);

  // One extra bit so DEPTH == 2**ADDR_WIDTH is still representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic {ST_LOAD, ST_RUN} state_e;

  state_e                state_q, state_d;
  logic [DEPTH-1:0]      written_q, written_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  instr_valid_q, instr_valid_d;
  logic                  fetch_err_q, fetch_err_d;
  logic                  fetch_uninit_q, fetch_uninit_d;
  logic                  load_err_q, load_err_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic load_in_range;
  logic fetch_in_range;
  logic mem_we;
  logic hold;
  logic accept;

  assign load_in_range  = {1'b0, load_addr} < DEPTH_LIM;
  assign fetch_in_range = {1'b0, fetch_addr} < DEPTH_LIM;
  assign mem_we         = (state_q == ST_LOAD) && load_we && load_in_range;

  // Fetch handshake: a request transfers on a cycle where fetch_req and
  // fetch_ready are both 1; the consumer takes instr on a cycle where
  // instr_valid is 1 and fetch_stall is 0, otherwise the result is held.
  assign hold        = instr_valid_q && fetch_stall;
  assign fetch_ready = (state_q == ST_RUN) && !hold;
  assign accept      = fetch_req && fetch_ready;

  always_comb begin
    state_d        = state_q;
    written_d      = written_q;
    instr_d        = instr_q;
    instr_valid_d  = instr_valid_q;
    fetch_err_d    = fetch_err_q;
    fetch_uninit_d = fetch_uninit_q;
    load_err_d     = load_we && ((state_q == ST_RUN) || !load_in_range);

    if (mem_we) begin
      written_d[load_addr] = 1'b1;
    end
    if (state_q == ST_LOAD && load_done) begin
      state_d = ST_RUN;
    end

    if (accept) begin
      instr_valid_d = 1'b1;
      if (!fetch_in_range) begin
        instr_d        = NOP_WORD;
        fetch_err_d    = 1'b1;
        fetch_uninit_d = 1'b0;
      end else if (!written_q[fetch_addr]) begin
        instr_d        = NOP_WORD;
        fetch_err_d    = 1'b0;
        fetch_uninit_d = 1'b1;
      end else begin
        instr_d        = mem_q[fetch_addr];
        fetch_err_d    = 1'b0;
        fetch_uninit_d = 1'b0;
      end
    end else if (!hold) begin
      instr_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_LOAD;
      written_q      <= '0;
      instr_q        <= NOP_WORD;
      instr_valid_q  <= 1'b0;
      fetch_err_q    <= 1'b0;
      fetch_uninit_q <= 1'b0;
      load_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      written_q      <= written_d;
      instr_q        <= instr_d;
      instr_valid_q  <= instr_valid_d;
      fetch_err_q    <= fetch_err_d;
      fetch_uninit_q <= fetch_uninit_d;
      load_err_q     <= load_err_d;
    end
  end

  // Array is deliberately not reset; stale words are masked by written_q.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[load_addr] <= load_data;
    end
  end

  assign running      = (state_q == ST_RUN);
  assign instr        = instr_q;
  assign instr_valid  = instr_valid_q;
  assign fetch_err    = fetch_err_q;
  assign fetch_uninit = fetch_uninit_q;
  assign load_err     = load_err_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Bench for instr_mem_loadable: directed vectors, a behavioural model checked
// every cycle, and literal expectations at key points.
module tb_instr_mem_loadable;
  localparam int DW    = 32;
  localparam int DEPTH = 24;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_we;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic          load_done;
  logic          load_err;
  logic          running;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_stall;
  logic          fetch_ready;
  logic [DW-1:0] instr;
  logic          instr_valid;
  logic          fetch_err;
  logic          fetch_uninit;

  int checks = 0;
  int errors = 0;

  instr_mem_loadable #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .NOP_WORD(32'h0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .load_done(load_done), .load_err(load_err), .running(running),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_stall(fetch_stall),
    .fetch_ready(fetch_ready), .instr(instr), .instr_valid(instr_valid),
    .fetch_err(fetch_err), .fetch_uninit(fetch_uninit)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- check helpers ----------------
  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_word(input string name, input logic [DW-1:0] act,
                            input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_mem [32];
  logic [31:0]   m_written;
  logic          m_running;
  logic          m_valid;
  logic [DW-1:0] m_instr;
  logic          m_ferr;
  logic          m_funinit;
  logic          m_lerr;
  logic          m_ready;

  assign m_ready = m_running && !(m_valid && fetch_stall);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_running <= 1'b0;
      m_written <= '0;
      m_valid   <= 1'b0;
      m_instr   <= 32'h0;
      m_ferr    <= 1'b0;
      m_funinit <= 1'b0;
      m_lerr    <= 1'b0;
    end else begin
      m_lerr <= load_we && (m_running || int'(load_addr) >= DEPTH);
      if (!m_running && load_we && int'(load_addr) < DEPTH) begin
        m_mem[int'(load_addr)]     <= load_data;
        m_written[int'(load_addr)] <= 1'b1;
      end
      if (!m_running && load_done) m_running <= 1'b1;
      if (fetch_req && m_ready) begin
        m_valid <= 1'b1;
        if (int'(fetch_addr) >= DEPTH) begin
          m_instr <= 32'h0; m_ferr <= 1'b1; m_funinit <= 1'b0;
        end else if (!m_written[int'(fetch_addr)]) begin
          m_instr <= 32'h0; m_ferr <= 1'b0; m_funinit <= 1'b1;
        end else begin
          m_instr <= m_mem[int'(fetch_addr)]; m_ferr <= 1'b0; m_funinit <= 1'b0;
        end
      end else if (!(m_valid && fetch_stall)) begin
        m_valid <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard compare (every cycle) ----------------
  always @(negedge clk) begin
    check_bit ("sb_running",      running,      m_running);
    check_bit ("sb_load_err",     load_err,     m_lerr);
    check_bit ("sb_fetch_ready",  fetch_ready,  m_ready);
    check_bit ("sb_instr_valid",  instr_valid,  m_valid);
    check_word("sb_instr",        instr,        m_instr);
    check_bit ("sb_fetch_err",    fetch_err,    m_ferr);
    check_bit ("sb_fetch_uninit", fetch_uninit, m_funinit);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    load_we = 1'b1; load_addr = a; load_data = d;
    tick();
    load_we = 1'b0;
  endtask

  task automatic fetch(input logic [AW-1:0] a);
    fetch_req = 1'b1; fetch_addr = a;
    tick();
  endtask

  task automatic expect_fetch(input string name, input logic [DW-1:0] d,
                              input logic err, input logic uninit);
    check_bit (name, instr_valid, 1'b1);
    check_word(name, instr, d);
    check_bit (name, fetch_err, err);
    check_bit (name, fetch_uninit, uninit);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    load_we = 1'b0; load_addr = '0; load_data = '0; load_done = 1'b0;
    fetch_req = 1'b0; fetch_addr = '0; fetch_stall = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check_word("rst_instr", instr, 32'h0);
    check_bit ("rst_valid", instr_valid, 1'b0);
    check_bit ("rst_running", running, 1'b0);

    // Fetch attempts in LOAD are never accepted.
    fetch_req = 1'b1; fetch_addr = 5'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_bit("load_ready", fetch_ready, 1'b0);
      check_bit("load_valid", instr_valid, 1'b0);
    end
    fetch_req = 1'b0;

    load_word(5'd0, 32'h20010003);
    load_word(5'd1, 32'h00221818);
    load_word(5'd24, 32'hFFFFFFFF);
    check_bit("oor_load_err", load_err, 1'b1);
    load_word(5'd23, 32'hA5A50017);
    check_bit("edge_load_err", load_err, 1'b0);
    load_word(5'd5, 32'h11111111);
    load_word(5'd5, 32'h22222222);
    load_done = 1'b1; tick(); load_done = 1'b0;
    check_bit("now_running", running, 1'b1);

    fetch(5'd1);  expect_fetch("f1",  32'h00221818, 1'b0, 1'b0);
    fetch(5'd0);  expect_fetch("f0",  32'h20010003, 1'b0, 1'b0);
    fetch(5'd7);  expect_fetch("f7",  32'h00000000, 1'b0, 1'b1);
    fetch(5'd30); expect_fetch("f30", 32'h00000000, 1'b1, 1'b0);
    fetch(5'd24); expect_fetch("f24", 32'h00000000, 1'b1, 1'b0);
    fetch(5'd23); expect_fetch("f23", 32'hA5A50017, 1'b0, 1'b0);
    fetch(5'd5);  expect_fetch("f5",  32'h22222222, 1'b0, 1'b0);
    fetch_req = 1'b0; tick();
    check_bit ("idle_valid", instr_valid, 1'b0);
    check_word("idle_instr", instr, 32'h22222222);

    // Stall hold.
    fetch(5'd0);
    fetch_stall = 1'b1; fetch_addr = 5'd1;
    #1 check_bit("stall_ready", fetch_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_fetch("stall_hold", 32'h20010003, 1'b0, 1'b0);
    end
    fetch_stall = 1'b0;
    #1 check_bit("unstall_ready", fetch_ready, 1'b1);
    tick();
    expect_fetch("after_stall", 32'h00221818, 1'b0, 1'b0);

    // Stall with nothing valid has no effect.
    fetch_req = 1'b0; tick();
    fetch_stall = 1'b1; fetch_req = 1'b1; fetch_addr = 5'd0;
    #1 check_bit("stall_idle_ready", fetch_ready, 1'b1);
    tick();
    expect_fetch("stall_idle", 32'h20010003, 1'b0, 1'b0);
    tick();
    expect_fetch("stall_idle_hold", 32'h20010003, 1'b0, 1'b0);
    fetch_stall = 1'b0; fetch_req = 1'b0; tick();

    // Writes in RUN are rejected.
    load_word(5'd2, 32'hDEADBEEF);
    check_bit("run_load_err", load_err, 1'b1);
    load_done = 1'b1;
    fetch(5'd2);
    load_done = 1'b0;
    check_bit("run_load_err_end", load_err, 1'b0);
    expect_fetch("f2_uninit", 32'h00000000, 1'b0, 1'b1);
    check_bit("still_running", running, 1'b1);
    fetch_req = 1'b0; tick();

    // Write and load_done in the same cycle.
    rst_n = 1'b0;
    #1 check_bit("rst2_running", running, 1'b0);
    tick();
    rst_n = 1'b1;
    load_we = 1'b1; load_addr = 5'd3; load_data = 32'h0C0FFEE3; load_done = 1'b1;
    tick();
    load_we = 1'b0; load_done = 1'b0;
    check_bit("wd_running", running, 1'b1);
    fetch(5'd3); expect_fetch("f3", 32'h0C0FFEE3, 1'b0, 1'b0);
    fetch(5'd0); expect_fetch("f0_stale", 32'h00000000, 1'b0, 1'b1);
    fetch(5'd3); expect_fetch("f3_again", 32'h0C0FFEE3, 1'b0, 1'b0);

    // Reset in the middle of a fetch stream.
    rst_n = 1'b0;
    #1;
    check_bit ("midrst_valid", instr_valid, 1'b0);
    check_bit ("midrst_running", running, 1'b0);
    check_word("midrst_instr", instr, 32'h0);
    tick();
    rst_n = 1'b1; fetch_req = 1'b0; load_done = 1'b1;
    tick();
    load_done = 1'b0;
    fetch(5'd0); expect_fetch("post_rst_f0", 32'h00000000, 1'b0, 1'b1);
    fetch(5'd3); expect_fetch("post_rst_f3", 32'h00000000, 1'b0, 1'b1);
    fetch_req = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
